// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side blocks: RAM handshake states, word type and arbiter request classes.
// Pure type/constant package; no logic, no latency.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Listed in arbitration priority order, highest first.
    typedef enum logic [1:0] {
        RC_DWRITE = 2'd0,
        RC_DREAD  = 2'd1,
        RC_IREAD  = 2'd2
    } req_class_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Circular first-set picker: scans req_i starting at ptr_i and returns the first requester.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);

    int c;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % N;
            if (req_i[c]) begin
                vld_o = 1'b1;
                idx_o = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates per-core icache/dcache misses onto one RAM port, one transaction in flight.
// Grant one cycle after request; wait drops combinationally on ACCESS; requesters stall on wait=1.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*ADDR_W-1:0]   iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*ADDR_W-1:0]   dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*ADDR_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [ADDR_W-1:0]        ramstore,
    input  logic [ADDR_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t          state_q, state_d;
    req_class_t          gclass_q, gclass_d;
    logic [CW-1:0]       gcore_q, gcore_d;
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   gaddr_q, gaddr_d;
    logic [ADDR_W-1:0]   gstore_q, gstore_d;

    logic [CPUS-1:0]     wr_req, rd_req;
    logic                wr_vld, rd_vld, i_vld;
    logic [CW-1:0]       wr_idx, rd_idx, i_idx;

    logic                pick_vld;
    req_class_t          pick_class;
    logic [CW-1:0]       pick_core;
    logic [ADDR_W-1:0]   pick_addr, pick_store;

    logic                held, in_grant, complete;

    // A core raising dWEN and dREN together is a single write.
    assign wr_req = dWEN;
    assign rd_req = dREN & ~dWEN;

    rr_picker #(.N(CPUS), .IW(CW)) u_pick_wr (.req_i(wr_req), .ptr_i(rr_ptr_q), .vld_o(wr_vld), .idx_o(wr_idx));
    rr_picker #(.N(CPUS), .IW(CW)) u_pick_rd (.req_i(rd_req), .ptr_i(rr_ptr_q), .vld_o(rd_vld), .idx_o(rd_idx));
    rr_picker #(.N(CPUS), .IW(CW)) u_pick_i  (.req_i(iREN),   .ptr_i(rr_ptr_q), .vld_o(i_vld),  .idx_o(i_idx));

    always_comb begin
        pick_vld   = wr_vld | rd_vld | i_vld;
        pick_class = RC_IREAD;
        pick_core  = i_idx;
        if (rd_vld) begin
            pick_class = RC_DREAD;
            pick_core  = rd_idx;
        end
        if (wr_vld) begin
            pick_class = RC_DWRITE;
            pick_core  = wr_idx;
        end
        pick_addr  = (pick_class == RC_IREAD) ? iaddr[int'(pick_core)*ADDR_W +: ADDR_W]
                                              : daddr[int'(pick_core)*ADDR_W +: ADDR_W];
        pick_store = (pick_class == RC_DWRITE) ? dstore[int'(pick_core)*ADDR_W +: ADDR_W] : '0;
    end

    // The granted requester must keep its enable up, otherwise the transaction is abandoned.
    always_comb begin
        held = 1'b0;
        case (gclass_q)
            RC_DWRITE: held = dWEN[gcore_q];
            RC_DREAD:  held = dREN[gcore_q];
            default:   held = iREN[gcore_q];
        endcase
    end

    assign in_grant = (state_q == ARB_GRANT) && held;
    assign complete = in_grant && (ramstate_t'(ramstate) == ACCESS);

    always_comb begin
        state_d  = state_q;
        gclass_d = gclass_q;
        gcore_d  = gcore_q;
        gaddr_d  = gaddr_q;
        gstore_d = gstore_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d  = ARB_GRANT;
                    gclass_d = pick_class;
                    gcore_d  = pick_core;
                    gaddr_d  = pick_addr;
                    gstore_d = pick_store;
                end
            end
            default: begin
                if (!held) begin
                    state_d = ARB_IDLE;
                end else if (complete) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (gcore_q == CW'(CPUS - 1)) ? '0 : gcore_q + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (in_grant) begin
            ramREN   = (gclass_q != RC_DWRITE);
            ramWEN   = (gclass_q == RC_DWRITE);
            ramaddr  = gaddr_q;
            ramstore = gstore_q;
        end
        if (complete) begin
            case (gclass_q)
                RC_DWRITE: dwait[gcore_q] = 1'b0;
                RC_DREAD: begin
                    dwait[gcore_q] = 1'b0;
                    dload[int'(gcore_q)*ADDR_W +: ADDR_W] = ramload;
                end
                default: begin
                    iwait[gcore_q] = 1'b0;
                    iload[int'(gcore_q)*ADDR_W +: ADDR_W] = ramload;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ARB_IDLE;
            gclass_q <= RC_IREAD;
            gcore_q  <= '0;
            gaddr_q  <= '0;
            gstore_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gclass_q <= gclass_d;
            gcore_q  <= gcore_d;
            gaddr_q  <= gaddr_d;
            gstore_q <= gstore_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two cores: priority, round robin, abort, ERROR hold and async reset.
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp;
    int n_err;

    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    mem_arbiter #(.CPUS(2), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = RS_FREE;
        #12;
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_dwait", 64'(dwait), 64'h3);
        chk("rst_ren_wen", 64'({ramREN, ramWEN}), 64'h0);
        chk("rst_ramaddr", 64'(ramaddr), 64'h0);
        chk("rst_ramstore", 64'(ramstore), 64'h0);
        chk("rst_loads", iload | dload, 64'h0);
        nRST = 1'b1;
        step();

        // Single read, ACCESS on the second grant cycle.
        iREN[0] = 1'b1; iaddr[31:0] = 32'h0000_0040; ramstate = RS_BUSY;
        settle();
        chk("rd_c0_idle_ren", 64'(ramREN), 64'h0);
        step();
        chk("rd_c1_ren", 64'(ramREN), 64'h1);
        chk("rd_c1_addr", 64'(ramaddr), 64'h40);
        chk("rd_c1_iwait", 64'(iwait), 64'h3);
        step();
        ramstate = RS_ACCESS; ramload = 32'hDEAD_BEEF;
        settle();
        chk("rd_c2_iwait", 64'(iwait), 64'h2);
        chk("rd_c2_iload", 64'(iload[31:0]), 64'hDEAD_BEEF);
        chk("rd_c2_addr", 64'(ramaddr), 64'h40);
        step();
        iREN[0] = 1'b0; ramstate = RS_FREE;
        settle();
        chk("rd_c3_iwait", 64'(iwait), 64'h3);
        chk("rd_c3_iload", iload, 64'h0);
        chk("rd_c3_ren", 64'(ramREN), 64'h0);
        step();

        // Class priority; rr_ptr is 1 here.
        iREN[0] = 1'b1; iaddr[31:0] = 32'h0000_0080;
        dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[63:32] = 32'h0000_0100; dstore[63:32] = 32'h1234_5678;
        ramstate = RS_ACCESS; ramload = 32'hCAFE_0001;
        step();
        chk("pri_wr_wen_ren", 64'({ramWEN, ramREN}), 64'h2);
        chk("pri_wr_store", 64'(ramstore), 64'h1234_5678);
        chk("pri_wr_addr", 64'(ramaddr), 64'h100);
        chk("pri_wr_dwait", 64'(dwait), 64'h1);
        chk("pri_wr_dload", dload, 64'h0);
        step();
        dREN[1] = 1'b0; dWEN[1] = 1'b0;
        settle();
        chk("pri_idle_en", 64'({ramWEN, ramREN}), 64'h0);
        step();
        chk("pri_i_ren", 64'({ramWEN, ramREN}), 64'h1);
        chk("pri_i_addr", 64'(ramaddr), 64'h80);
        chk("pri_i_iwait", 64'(iwait), 64'h2);
        chk("pri_i_iload", 64'(iload[31:0]), 64'hCAFE_0001);
        step();
        iREN[0] = 1'b0; ramstate = RS_FREE;
        step();

        // Abort core1 fetch; rr_ptr must stay 1.
        iREN[1] = 1'b1; iaddr[63:32] = 32'h0000_0200; ramstate = RS_BUSY;
        step();
        chk("ab_ren", 64'(ramREN), 64'h1);
        chk("ab_addr", 64'(ramaddr), 64'h200);
        iREN[1] = 1'b0;
        settle();
        chk("ab_drop_ren", 64'(ramREN), 64'h0);
        chk("ab_drop_iwait", 64'(iwait), 64'h3);
        step();
        chk("ab_idle_ren", 64'(ramREN), 64'h0);
        iREN = 2'b11; iaddr[31:0] = 32'h0000_0300; ramstate = RS_ACCESS; ramload = 32'h0BAD_F00D;
        step();
        chk("ab_next_addr", 64'(ramaddr), 64'h200);
        chk("ab_next_iwait", 64'(iwait), 64'h1);
        chk("ab_next_iload", iload, {32'h0BAD_F00D, 32'h0});
        step();
        iREN = 2'b00; ramstate = RS_FREE;
        step();

        // Round robin with both cores reading and zero-latency ACCESS; rr_ptr is 0.
        dREN = 2'b11; daddr = {32'h0000_2000, 32'h0000_1000}; ramstate = RS_ACCESS; ramload = 32'h7777_0000;
        for (int t = 0; t < 8; t++) begin
            step();
            chk($sformatf("rr%0d_addr", t), 64'(ramaddr), (t % 2 == 1) ? 64'h2000 : 64'h1000);
            chk($sformatf("rr%0d_dwait", t), 64'(dwait), (t % 2 == 1) ? 64'h1 : 64'h2);
            step();
            if (t == 7) dREN = 2'b00;
        end
        ramstate = RS_FREE;
        step();

        // ERROR holds the grant; rr_ptr is 0.
        dWEN[0] = 1'b1; daddr[31:0] = 32'h0000_4000; dstore[31:0] = 32'h55AA_55AA; ramstate = RS_ERROR;
        step();
        for (int e = 0; e < 5; e++) begin
            chk($sformatf("err%0d_dwait", e), 64'(dwait), 64'h3);
            chk($sformatf("err%0d_addr", e), 64'(ramaddr), 64'h4000);
            chk($sformatf("err%0d_wen", e), 64'(ramWEN), 64'h1);
            step();
        end
        ramstate = RS_ACCESS;
        settle();
        chk("err_done_dwait", 64'(dwait), 64'h2);
        chk("err_done_addr", 64'(ramaddr), 64'h4000);
        chk("err_done_store", 64'(ramstore), 64'h55AA_55AA);
        step();
        dWEN[0] = 1'b0; ramstate = RS_FREE;
        step();

        // Async reset during grant; rr_ptr is 1 beforehand.
        iREN[0] = 1'b1; iaddr[31:0] = 32'h0000_0500; ramstate = RS_BUSY;
        step();
        chk("rg_ren", 64'(ramREN), 64'h1);
        #1 nRST = 1'b0;
        #1;
        chk("rg_rst_en", 64'({ramREN, ramWEN}), 64'h0);
        chk("rg_rst_iwait", 64'(iwait), 64'h3);
        chk("rg_rst_addr", 64'(ramaddr), 64'h0);
        step();
        nRST = 1'b1;
        iREN = 2'b11; iaddr[63:32] = 32'h0000_0600; ramstate = RS_ACCESS; ramload = 32'h1111_2222;
        step();
        chk("rg_post_addr", 64'(ramaddr), 64'h500);
        chk("rg_post_iwait", 64'(iwait), 64'h2);
        chk("rg_post_iload", iload, {32'h0, 32'h1111_2222});
        step();
        iREN = 2'b00; ramstate = RS_FREE;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the per-core icache and dcache. Arbitrates their miss/writeback requests onto the single shared RAM port.
- Serves CPUS cores, each with one instruction and one data requester. Exactly one RAM transaction is outstanding at a time.
- Returns per-requester wait/load handshakes with the same semantics the caches already consume: wait high until data is valid or the write is committed.

Parameters:
CPUS, 2, number of cores (1..4); requesters = 2*CPUS
ADDR_W, 32, address and data word width

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  CPUS  per-core instruction read request
iaddr  in  CPUS*ADDR_W  per-core instruction address, core c at bits [c*32+:32]
iwait  out  CPUS  per-core instruction wait, active high
iload  out  CPUS*ADDR_W  per-core instruction data
dREN  in  CPUS  per-core data read request
dWEN  in  CPUS  per-core data write request
daddr  in  CPUS*ADDR_W  per-core data address
dstore  in  CPUS*ADDR_W  per-core write data
dwait  out  CPUS  per-core data wait, active high
dload  out  CPUS*ADDR_W  per-core read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  ADDR_W  RAM write data
ramload  in  ADDR_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset values: all waits = 1, all load buses = 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0, state = IDLE, rr_ptr = 0, grant = none.
- Request classes, in priority order: data write (dWEN), then data read (dREN), then instruction (iREN). dWEN and dREN both high on one core counts as a write.
- Within a class, cores are scanned circularly starting at rr_ptr.
- IDLE: if any request is present, the winner's id (core, class) plus its address and store data are registered; next cycle the state is GRANT. With no request, stay in IDLE.
- GRANT:
  - ramREN/ramWEN/ramaddr/ramstore are driven from the registered grant.
  - ramaddr is stable for the whole grant.
  - ramWEN=1 only for the write class.
- GRANT completion: the cycle ramstate==ACCESS, the granted requester's wait goes 0 combinationally and its load is driven from ramload (reads only). Next cycle the state is IDLE and rr_ptr = (granted core + 1) mod CPUS.
- ramstate FREE/BUSY/ERROR while in GRANT: wait stays 1 and the state holds. ERROR is never completed.
- Minimum latency: request at cycle 0, RAM enables at cycle 1. If RAM returns ACCESS at cycle 1, wait=0 at cycle 1 and a new grant can start at cycle 3 (IDLE at cycle 2).
- Non-granted requesters: wait=1 and load=0 at all times.
- Abort: if the granted requester's enable drops while in GRANT, RAM enables are deasserted that cycle, the state returns to IDLE, rr_ptr is unchanged and no wait-low pulse is generated.
- Requests raised during GRANT are not considered until IDLE. Requesters must hold address and data stable until wait is low.
- Async reset mid-GRANT: immediate return to reset values; the RAM sees its enables drop the same instant.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t enum {FREE, BUSY, ACCESS, ERROR}, word_t, and a new req_class_t {RC_DWRITE, RC_DREAD, RC_IREAD}.
- One sub-module, rr_picker: given a CPUS-bit request vector and rr_ptr, it returns a valid bit and the winning core index. It is combinational and instantiated once per class.

Test Plan:
- Single read: core0 iREN, iaddr=0x0000_0040, RAM returns ACCESS on the 2nd GRANT cycle with ramload=0xDEAD_BEEF -> ramaddr=0x40 and ramREN=1 from cycle 1; iwait[0]=0 and iload[0]=0xDEAD_BEEF at cycle 2 only.
- Class priority: same cycle core0 iREN, core1 dREN, core1 dWEN with dstore=0x1234_5678 -> write granted first (ramWEN=1, ramstore=0x1234_5678), then the core1 dcache read is treated as the same request, then core0 instruction.
- Round robin: core0 and core1 both hold dREN continuously with zero-latency ACCESS -> grants alternate 0,1,0,1; neither is starved across 8 transactions.
- Abort: grant core1 iREN, drop iREN while ramstate=BUSY -> ramREN=0 that cycle, IDLE next cycle, iwait[1] never 0, next grant still starts search at the old rr_ptr.
- ERROR/hold: ramstate=ERROR for 5 cycles, then ACCESS -> wait stays 1 throughout ERROR and completes only on ACCESS; ramaddr is unchanged throughout.
- Reset mid-GRANT: assert nRST=0 asynchronously during GRANT -> ramREN/ramWEN=0 immediately, all waits=1; after release, a fresh request is served normally with rr_ptr=0.
